// File: rtl/bus_slave_responder.sv
// Slave-side bus endpoint: accepts one cs_/as_ request at a time, serves it
// from a local register bank after WAIT_CYCLES wait states, pulses rdy_.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset_    in   asynchronous reset, active-low
//   cs_       in   chip select, active-low (high during wait aborts)
//   as_       in   address strobe, active-low, one cycle per request
//   rw        in   1 = read, 0 = write
//   addr      in   word address, low REG_IDX_W bits decoded
//   wr_data   in   write data, valid in the as_ cycle
//   rd_data   out  read data while rdy_ is low, else zero
//   rdy_      out  one-cycle active-low completion pulse
//   busy      out  high from cycle after accept through the rdy_ cycle
//   ctrl_out  out  continuous copy of register 0
module bus_slave_responder #(
    parameter int REG_NUM     = 8,
    parameter int REG_IDX_W   = 3,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        cs_,
    input  logic        as_,
    input  logic        rw,
    input  logic [29:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rdy_,
    output logic        busy,
    output logic [31:0] ctrl_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_READY
    } state_t;

    state_t               state;
    logic [3:0]           cnt;
    logic [31:0]          regs [REG_NUM];
    logic                 lat_rw;
    logic [REG_IDX_W-1:0] lat_idx;
    logic [31:0]          lat_wd;

    logic                 req;
    logic                 go_rdy;
    logic                 src_rw;
    logic [REG_IDX_W-1:0] src_idx;
    logic [31:0]          src_wd;

    // Upper address bits alias onto the bank by design.
    logic unused_addr;
    assign unused_addr = ^addr[29:REG_IDX_W];

    assign ctrl_out = regs[0];

    // go_rdy marks the edge that enters READY. With zero wait states the
    // request is served straight from the bus, otherwise from the latch.
    always_comb begin
        req     = !cs_ && !as_;
        go_rdy  = 1'b0;
        src_rw  = lat_rw;
        src_idx = lat_idx;
        src_wd  = lat_wd;
        unique case (state)
            S_IDLE: begin
                go_rdy  = req && (WAIT_CYCLES == 0);
                src_rw  = rw;
                src_idx = addr[REG_IDX_W-1:0];
                src_wd  = wr_data;
            end
            S_WAIT:  go_rdy = !cs_ && (cnt == 4'd0);
            default: go_rdy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            rdy_    <= 1'b1;
            rd_data <= 32'h0;
            busy    <= 1'b0;
            lat_rw  <= 1'b0;
            lat_idx <= '0;
            lat_wd  <= 32'h0;
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (go_rdy) begin
            state <= S_READY;
            rdy_  <= 1'b0;
            busy  <= 1'b1;
            cnt   <= 4'd0;
            if (src_rw) begin
                rd_data <= regs[src_idx];
            end else begin
                regs[src_idx] <= src_wd;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        lat_rw  <= rw;
                        lat_idx <= addr[REG_IDX_W-1:0];
                        lat_wd  <= wr_data;
                        busy    <= 1'b1;
                        state   <= S_WAIT;
                        cnt     <= 4'(WAIT_CYCLES - 1);
                    end
                end
                S_WAIT: begin
                    // Losing chip select abandons the request silently.
                    if (cs_) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_READY: begin
                    state   <= S_IDLE;
                    rdy_    <= 1'b1;
                    rd_data <= 32'h0;
                    busy    <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_slave_responder.sv
// Scoreboard bench for bus_slave_responder: three instances with 2, 0 and
// 15 wait states share the bus, each selected by its own chip select.
module tb_bus_slave_responder;

    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          reset_;
    logic [NI-1:0] cs_;
    logic          as_;
    logic          rw;
    logic [29:0]   addr;
    logic [31:0]   wr_data;
    logic [31:0]   rd_data [NI];
    logic [NI-1:0] rdy_;
    logic [NI-1:0] busy;
    logic [31:0]   ctrl_out [NI];

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    typedef struct {
        int          inst;
        int          cyc;
        logic [31:0] data;
        logic [31:0] ctrl;
    } exp_t;

    exp_t        sb [$];
    exp_t        mon_e;
    logic [31:0] model [NI][8];

    bus_slave_responder #(.WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .reset_(reset_), .cs_(cs_[0]), .as_(as_), .rw(rw),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data[0]),
        .rdy_(rdy_[0]), .busy(busy[0]), .ctrl_out(ctrl_out[0])
    );

    bus_slave_responder #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset_(reset_), .cs_(cs_[1]), .as_(as_), .rw(rw),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data[1]),
        .rdy_(rdy_[1]), .busy(busy[1]), .ctrl_out(ctrl_out[1])
    );

    bus_slave_responder #(.WAIT_CYCLES(15)) u_w15 (
        .clk(clk), .reset_(reset_), .cs_(cs_[2]), .as_(as_), .rw(rw),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data[2]),
        .rdy_(rdy_[2]), .busy(busy[2]), .ctrl_out(ctrl_out[2])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wc_of(int i);
        return (i == 0) ? 2 : (i == 1) ? 0 : 15;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NI; i++)
            for (int j = 0; j < 8; j++)
                model[i][j] = 32'h0;
    endtask

    // Pop one expectation per rdy_ pulse; rd_data must be zero otherwise.
    always @(negedge clk) begin
        if (reset_ === 1'b1) begin
            for (int i = 0; i < NI; i++) begin
                if (rdy_[i] !== 1'b1) begin
                    if (sb.size() == 0) begin
                        check("spurious_rdy", 32'(i), 32'hFFFF_FFFF);
                    end else begin
                        mon_e = sb.pop_front();
                        check("rdy_inst", 32'(i), 32'(mon_e.inst));
                        check("rdy_cyc", 32'(cyc), 32'(mon_e.cyc));
                        check("rd_data", rd_data[i], mon_e.data);
                        check("ctrl_out", ctrl_out[i], mon_e.ctrl);
                    end
                end else begin
                    check("rd_idle", rd_data[i], 32'h0);
                end
            end
        end
    end

    task automatic xact(int i, bit rd, logic [29:0] a, logic [31:0] d,
                        bit dbl);
        int   c0;
        int   w;
        exp_t e;
        w = wc_of(i);
        @(posedge clk); #1;
        rw      = rd;
        addr    = a;
        wr_data = d;
        as_     = 1'b0;
        cs_[i]  = 1'b0;
        c0      = cyc;
        if (rd) begin
            e.data = model[i][a[2:0]];
        end else begin
            e.data = 32'h0;
            model[i][a[2:0]] = d;
        end
        e.inst = i;
        e.cyc  = c0 + w + 1;
        e.ctrl = model[i][0];
        sb.push_back(e);
        for (int k = 0; k <= w + 2; k++) begin
            @(negedge clk);
            check("busy", 32'(busy[i]), 32'((k >= 1) && (k <= w + 1)));
            @(posedge clk); #1;
            if (k == 0) begin
                as_     = dbl ? 1'b0 : 1'b1;
                addr    = 30'($urandom);
                wr_data = $urandom;
                rw      = 1'($urandom);
            end
            if (k == 1) as_ = 1'b1;
        end
        cs_ = '1;
    endtask

    initial begin
        reset_  = 1'b0;
        cs_     = '1;
        as_     = 1'b1;
        rw      = 1'b0;
        addr    = '0;
        wr_data = '0;
        clear_model();

        // Reset with noisy bus.
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            cs_     = 3'($urandom);
            as_     = 1'($urandom);
            rw      = 1'($urandom);
            addr    = 30'($urandom);
            wr_data = $urandom;
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                check("rst_rdy", 32'(rdy_[i]), 32'h1);
                check("rst_rd", rd_data[i], 32'h0);
                check("rst_busy", 32'(busy[i]), 32'h0);
                check("rst_ctrl", ctrl_out[i], 32'h0);
            end
        end
        @(posedge clk); #1;
        cs_    = '1;
        as_    = 1'b1;
        reset_ = 1'b1;

        xact(0, 1, 30'd5, 32'h0, 0);

        // Basic write/read.
        xact(0, 0, 30'd3, 32'hDEADBEEF, 0);
        xact(0, 1, 30'd3, 32'h0, 0);

        // Control word and aliasing onto index 0.
        xact(0, 0, 30'd0, 32'h0000_00A5, 0);
        xact(0, 0, 30'd8, 32'h5A5A_1234, 0);
        xact(0, 1, 30'h3FFF_FFF8, 32'h0, 0);

        // Abort during wait keeps previous contents.
        xact(0, 0, 30'd2, 32'h0000_0077, 0);
        @(posedge clk); #1;
        rw      = 1'b0;
        addr    = 30'd2;
        wr_data = 32'h1234;
        as_     = 1'b0;
        cs_[0]  = 1'b0;
        @(posedge clk); #1;
        as_     = 1'b1;
        cs_[0]  = 1'b1;
        @(negedge clk);
        check("abort_busy_on", 32'(busy[0]), 32'h1);
        @(negedge clk);
        check("abort_busy_off", 32'(busy[0]), 32'h0);
        repeat (4) @(posedge clk);
        xact(0, 1, 30'd2, 32'h0, 0);

        // Strobe without chip select is ignored.
        @(posedge clk); #1;
        cs_     = '1;
        as_     = 1'b0;
        rw      = 1'b0;
        addr    = 30'd1;
        wr_data = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        as_ = 1'b1;
        @(negedge clk);
        check("nocs_busy", 32'(busy[0]), 32'h0);
        repeat (3) @(posedge clk);

        // Second strobe while busy, then back-to-back reads.
        xact(0, 0, 30'd1, 32'h1111_0001, 1);
        xact(0, 1, 30'd1, 32'h0, 0);
        xact(0, 1, 30'd2, 32'h0, 0);
        xact(1, 0, 30'd6, 32'hC0DE_0006, 1);
        xact(1, 1, 30'd6, 32'h0, 0);
        xact(1, 0, 30'd0, 32'h0F0F_0F0F, 0);

        // Wait-state extremes.
        xact(2, 0, 30'd7, 32'hFACE_0007, 0);
        xact(2, 1, 30'd7, 32'h0, 0);

        // Short random mix.
        for (int n = 0; n < 12; n++) begin
            xact(int'($urandom_range(0, NI - 1)), 1'($urandom),
                 30'($urandom), $urandom, 0);
        end

        // Async reset mid-wait drops busy immediately.
        @(posedge clk); #1;
        rw      = 1'b0;
        addr    = 30'd4;
        wr_data = 32'h4444_4444;
        as_     = 1'b0;
        cs_[2]  = 1'b0;
        @(posedge clk); #1;
        as_ = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check("pre_rst_busy", 32'(busy[2]), 32'h1);
        reset_ = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy[2]), 32'h0);
        check("mid_rst_rdy", 32'(rdy_[2]), 32'h1);
        check("mid_rst_ctrl", ctrl_out[2], 32'h0);
        clear_model();
        cs_ = '1;
        @(posedge clk); #1;
        reset_ = 1'b1;
        xact(2, 1, 30'd4, 32'h0, 0);
        xact(0, 1, 30'd3, 32'h0, 0);

        repeat (4) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
